// File: rtl/uart_stream_fifo.sv
// UART receive-to-stream FIFO with an optional loopback drain into the UART transmitter.
// Latency: a pop presents rd_data/rd_valid on the next cycle; loopback issues tx_wr 2 cycles after leaving L_IDLE.
// Backpressure: when full, an accepted word is dropped and overflow is flagged. Loopback waits on tx_busy.
// Build option: define UART_STREAM_FIFO_DROPCNT_EN to get a saturating dropped-word counter on drop_count.
module uart_stream_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 53,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    input  logic                         rx_avail,
    output logic                         rx_ack,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         clr_ovf,
    input  logic                         loopback,
    output logic [DATA_WIDTH-1:0]        tx_data,
    output logic                         tx_wr,
    input  logic                         tx_busy,
    output logic [15:0]                  drop_count
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    localparam logic [1:0] L_IDLE = 2'd0;
    localparam logic [1:0] L_POP  = 2'd1;
    localparam logic [1:0] L_WR   = 2'd2;
    localparam logic [1:0] L_WAIT = 2'd3;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_d;
    logic                  empty_q;
    logic                  full_q;
    logic                  afull_q;
    logic                  armed_q;
    logic                  rx_ack_q;
    logic                  rd_valid_q;
    logic                  ovf_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [1:0]            state_q;
    logic [1:0]            state_d;

    logic accept;
    logic lb_pop;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // armed blocks a second accept until rx_avail has been seen low.
    always_comb begin
        accept = rx_avail && !armed_q;
        lb_pop = (state_q == L_POP);
        pop    = ((rd_en && !loopback) || lb_pop) && !empty_q;
        push   = accept && (!full_q || pop);
        drop   = accept && !push;
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // An in-flight transfer always runs to L_WAIT/L_IDLE; loopback only gates the start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            L_IDLE:  if (loopback && !empty_q && !tx_busy) state_d = L_POP;
            L_POP:   state_d = L_WR;
            L_WR:    state_d = L_WAIT;
            L_WAIT:  if (!tx_busy) state_d = L_IDLE;
            default: state_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            armed_q    <= 1'b0;
            rx_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            tx_data_q  <= '0;
            state_q    <= L_IDLE;
        end else begin
            if (accept)        armed_q <= 1'b1;
            else if (!rx_avail) armed_q <= 1'b0;
            rx_ack_q   <= accept;
            rd_valid_q <= pop;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop) begin
                rd_ptr_q  <= ptr_inc(rd_ptr_q);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            if (lb_pop) tx_data_q <= mem_q[rd_ptr_q];
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == DEPTH_L);
            afull_q <= (level_d >= AFULL_L);
            if (clr_ovf)   ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
            state_q <= state_d;
        end
    end

`ifdef UART_STREAM_FIFO_DROPCNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else if (clr_ovf) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'h0000;
`endif

    assign rx_ack      = rx_ack_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign tx_data     = tx_data_q;
    assign tx_wr       = (state_q == L_WR);

endmodule

// File: tb/tb_uart_stream_fifo.sv
// Scoreboard bench for uart_stream_fifo: a queue-based reference model predicts pops and transmits,
// an independent monitor compares every rd_valid / tx_wr / rx_ack the DUT produces.
module tb_uart_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 53;
    localparam int AFULL = DEPTH - 4;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef UART_STREAM_FIFO_DROPCNT_EN
    localparam int DC_AFTER_FILL = 7;
`else
    localparam int DC_AFTER_FILL = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          rx_avail;
    logic          rx_ack;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clr_ovf;
    logic          loopback;
    logic [DW-1:0] tx_data;
    logic          tx_wr;
    logic          tx_busy;
    logic [15:0]   drop_count;

    uart_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
        .almost_full(almost_full), .level(level), .overflow(overflow), .clr_ovf(clr_ovf),
        .loopback(loopback), .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .drop_count(drop_count)
    );

    initial forever #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] exp_tx[$];
    bit            m_prev = 1'b0;
    bit            m_ovf  = 1'b0;
    int            m_cnt  = 0;
    int            exp_ack = 0;
    logic [DW-1:0] m_last_rd = '0;
    logic [DW-1:0] m_last_tx = '0;

    // Monitor state
    int ack_cnt = 0;
    int tx_cnt  = 0;
    int cyc     = 0;
    int last_tx_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    function automatic int exp_dc();
`ifdef UART_STREAM_FIFO_DROPCNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // One clock of the spec: one accept per rx_avail high run, pop only when non-empty,
    // write when not full or popping, otherwise drop; clr_ovf wins.
    task automatic model_step();
        bit acc;
        bit pp;
        bit was_full;
        logic [DW-1:0] v;
        acc      = rx_avail && !m_prev;
        m_prev   = rx_avail;
        was_full = (mq.size() == DEPTH);
        pp       = rd_en && !loopback && (mq.size() > 0);
        if (pp) begin
            v = mq.pop_front();
            exp_rd.push_back(v);
            m_last_rd = v;
        end
        if (acc) begin
            exp_ack++;
            if (!was_full || pp) mq.push_back(rx_data);
            else begin
                m_ovf = 1'b1;
                if (m_cnt != 65535) m_cnt++;
            end
        end
        if (clr_ovf) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic check_status(input string t);
        #1;
        chk({t, "_level"}, 32'(level), mq.size());
        chk({t, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({t, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({t, "_afull"}, 32'(almost_full), 32'(mq.size() >= AFULL));
        chk({t, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({t, "_dropcnt"}, 32'(drop_count), exp_dc());
        chk({t, "_acks"}, ack_cnt, exp_ack);
    endtask

    task automatic reset_checks(input string t);
        chk({t, "_level"}, 32'(level), 0);
        chk({t, "_empty"}, 32'(empty), 1);
        chk({t, "_full"}, 32'(full), 0);
        chk({t, "_afull"}, 32'(almost_full), 0);
        chk({t, "_ovf"}, 32'(overflow), 0);
        chk({t, "_rx_ack"}, 32'(rx_ack), 0);
        chk({t, "_rd_valid"}, 32'(rd_valid), 0);
        chk({t, "_tx_wr"}, 32'(tx_wr), 0);
        chk({t, "_rd_data"}, 32'(rd_data), 0);
        chk({t, "_tx_data"}, 32'(tx_data), 0);
        chk({t, "_dropcnt"}, 32'(drop_count), 0);
    endtask

    task automatic push_word(input logic [DW-1:0] d, input int hold);
        rx_avail = 1'b1;
        rx_data  = d;
        repeat (hold) cycle();
        rx_avail = 1'b0;
        rx_data  = DW'($urandom);
        cycle();
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) cycle();
        rd_en = 1'b0;
    endtask

    task automatic drain(input string t);
        int b;
        b = 0;
        rd_en = 1'b1;
        while (mq.size() > 0 && b < DEPTH + 4) begin
            cycle();
            b++;
        end
        rd_en = 1'b0;
        cycle();
        check_status(t);
    endtask

    // Monitor: decoupled checking of every output event against the scoreboard queues.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
            if (rx_ack) ack_cnt++;
            if (rd_valid) begin
                if (exp_rd.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid), 0);
                else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            if (tx_wr) begin
                if (exp_tx.size() == 0) chk("tx_wr_unexpected", 32'(tx_wr), 0);
                else begin
                    m_last_tx = exp_tx.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(m_last_tx));
                end
                if (tx_cnt > 0) chk("tx_gap_ge_11", 32'((cyc - last_tx_cyc) >= 11), 1);
                tx_cnt++;
                last_tx_cyc = cyc;
            end else begin
                chk("tx_data_hold", 32'(tx_data), 32'(m_last_tx));
            end
        end
    end

    // Transmitter peer: busy from the cycle after tx_wr for 10 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx_wr) begin
                @(negedge clk);
                tx_busy = 1'b1;
                repeat (10) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        int tx0;
        int b;
        logic [DW-1:0] v;
        reset    = 1'b0;
        rx_data  = '0;
        rx_avail = 1'b0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        loopback = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("rst");
        @(negedge clk);
        reset = 1'b1;

        // Single word held for 5 cycles
        rx_avail = 1'b1;
        rx_data  = 8'hA5;
        repeat (5) cycle();
        rx_avail = 1'b0;
        cycle();
        check_status("hold5");
        chk("hold5_one_ack", ack_cnt, 1);
        chk("hold5_level1", 32'(level), 1);
        pop_n(1);
        cycle();
        check_status("hold5_pop");

        // Pop requests while empty
        pop_n(3);
        cycle();
        check_status("rd_empty");
        chk("rd_empty_data_held", 32'(rd_data), 32'(8'hA5));

        // Overfill with 60 sequential words
        for (int i = 0; i < 60; i++) begin
            push_word(DW'(i), int'($urandom_range(1, 3)));
            check_status($sformatf("fill%0d", i));
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_overflow", 32'(overflow), 1);
        chk("fill_dropcnt", 32'(drop_count), DC_AFTER_FILL);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1;
            cycle();
            rd_en = 1'b0;
            if ($urandom_range(0, 1) == 1) cycle();
        end
        cycle();
        check_status("fill_drain");
        chk("fill_drain_all_seen", exp_rd.size(), 0);

        // Refill, drop, then drop with clear in the same cycle
        while (mq.size() < DEPTH) push_word(DW'($urandom), 1);
        push_word(DW'($urandom), 1);
        check_status("drop_at_full");
        rx_avail = 1'b1;
        rx_data  = DW'($urandom);
        clr_ovf  = 1'b1;
        cycle();
        rx_avail = 1'b0;
        clr_ovf  = 1'b0;
        cycle();
        check_status("clr_wins");
        chk("clr_wins_ovf", 32'(overflow), 0);

        // Accept and pop in the same cycle at full
        rx_avail = 1'b1;
        rx_data  = 8'hC3;
        rd_en    = 1'b1;
        cycle();
        rx_avail = 1'b0;
        rd_en    = 1'b0;
        cycle();
        check_status("simul");
        chk("simul_level", 32'(level), DEPTH);
        chk("simul_ovf", 32'(overflow), 0);
        drain("simul_drain");
        chk("simul_last_word", 32'(rd_data), 32'(8'hC3));

        // Randomised traffic: fill-biased, then drain-biased
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 400; i++) begin
                rx_avail = ($urandom_range(0, 1) == 1);
                rx_data  = DW'($urandom);
                rd_en    = (ph == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
                clr_ovf  = ($urandom_range(0, 40) == 0);
                cycle();
                check_status("rnd");
            end
        end
        rx_avail = 1'b0;
        clr_ovf  = 1'b0;
        cycle();
        drain("rnd_drain");

        // Loopback drain of 3 words
        for (int i = 0; i < 3; i++) push_word(DW'($urandom), 2);
        while (mq.size() > 0) begin
            v = mq.pop_front();
            exp_tx.push_back(v);
            exp_rd.push_back(v);
            m_last_rd = v;
        end
        tx0 = tx_cnt;
        loopback = 1'b1;
        b = 0;
        while ((tx_cnt - tx0) < 3 && b < 200) begin
            cycle();
            b++;
        end
        repeat (15) cycle();
        chk("lb_tx_count", tx_cnt - tx0, 3);
        chk("lb_empty", 32'(empty), 1);
        chk("lb_tx_all_seen", exp_tx.size(), 0);
        loopback = 1'b0;
        cycle();
        check_status("lb_done");

        // Reset while the transfer sits in L_WAIT with 4 words left
        for (int i = 0; i < 5; i++) push_word(DW'($urandom), 1);
        v = mq.pop_front();
        exp_tx.push_back(v);
        exp_rd.push_back(v);
        m_last_rd = v;
        tx0 = tx_cnt;
        loopback = 1'b1;
        b = 0;
        while (tx_cnt == tx0 && b < 50) begin
            cycle();
            b++;
        end
        repeat (3) cycle();
        #1;
        chk("wait_level4", 32'(level), 4);
        chk("wait_busy", 32'(tx_busy), 1);
        #1;
        reset = 1'b0;
        #1;
        reset_checks("async_rst");
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        m_last_rd = '0;
        m_last_tx = '0;
        m_prev = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) cycle();
        chk("post_rst_no_tx", tx_cnt - tx0, 1);
        loopback = 1'b0;
        cycle();
        check_status("post_rst");

        chk("end_rd_queue_empty", exp_rd.size(), 0);
        chk("end_tx_queue_empty", exp_tx.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_stream_fifo.md
UART_STREAM_FIFO -- requirements
Module: uart_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 53: number of entries; legal range 2..1024, power of two not required.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-4: level at or above which almost_full asserts.
REQ-004 SHALL have ports, with clock and reset first:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- rx_data  in  DATA_WIDTH  received word from the UART.
- rx_avail  in  1  UART word-available level.
- rx_ack  out  1  one-cycle acknowledge to the UART.
- rd_en  in  1  pop request; ignored when loopback=1.
- rd_data  out  DATA_WIDTH  popped word.
- rd_valid  out  1  rd_data valid for one cycle.
- empty, full, almost_full  out  1 each  status flags.
- level  out  clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky word-dropped flag.
- clr_ovf  in  1  clears overflow.
- loopback  in  1  drain mode: FIFO output goes to the UART transmitter.
- tx_data  out  DATA_WIDTH  word to transmit.
- tx_wr  out  1  one-cycle transmit strobe.
- tx_busy  in  1  UART transmitter busy.
- drop_count  out  16  dropped-word counter (see Configuration).

Function
REQ-005 SHALL accept a word in a cycle where rx_avail=1 and the internal armed flag=0; on accept, armed SHALL set and clear only in a cycle where rx_avail=0, giving one accept per rx_avail assertion.
REQ-006 SHALL drive rx_ack=1 for exactly the cycle after each accept, including dropped words.
REQ-007 SHALL write an accepted word when full=0, or when full=1 and a pop occurs in the same cycle; otherwise it SHALL drop the word and set overflow.
REQ-008 SHALL pop when (rd_en=1 and loopback=0, or a loopback pop occurs) and empty=0. rd_data SHALL update and rd_valid=1 in the next cycle. A pop request while empty SHALL be ignored, leaving rd_valid=0 and rd_data held.
REQ-009 SHALL wrap the write and read pointers from DEPTH-1 to 0.
REQ-010 SHALL update level by +1 on write only, -1 on pop only, and 0 on both; empty=(level==0), full=(level==DEPTH), almost_full=(level>=AFULL_LEVEL), all registered consistent with level.
REQ-011 SHALL implement the loopback FSM as L_IDLE, L_POP, L_WR, L_WAIT:
- L_IDLE->L_POP when loopback=1, empty=0 and tx_busy=0; L_POP pops one word.
- L_POP->L_WR; in L_WR, tx_wr=1 and tx_data=popped word.
- L_WR->L_WAIT; L_WAIT->L_IDLE when tx_busy=0.
REQ-012 SHALL hold tx_data stable from L_WR until the next L_WR, and keep tx_wr=0 outside L_WR.
REQ-013 SHALL complete an in-flight loopback transfer through to L_IDLE if loopback deasserts mid-transfer, with no further pops after that.
REQ-014 SHALL require the peer to raise tx_busy in the cycle after tx_wr.
REQ-015 SHALL give clr_ovf priority over a same-cycle overflow set (clear wins).

Reset
REQ-016 SHALL, while reset=0, asynchronously force:
- pointers, level, armed and overflow to 0; FIFO contents discarded;
- rx_ack, rd_valid, tx_wr, full and almost_full to 0; empty to 1;
- rd_data, tx_data and drop_count to 0; FSM to L_IDLE.
REQ-017 SHALL resume normal operation on the first rising clk edge after reset returns to 1; a reset during a loopback transfer SHALL abort it with no tx_wr.

Configuration
REQ-018 SHALL, with macro UART_STREAM_FIFO_DROPCNT_EN defined, increment drop_count on every dropped word, saturating at 16'hFFFF, and clear it on clr_ovf.
REQ-019 SHALL, without UART_STREAM_FIFO_DROPCNT_EN, tie drop_count to 16'h0000 and synthesise no counter logic.

Verification
REQ-020 Bench SHALL cover:
- rx_avail held high for 5 cycles with rx_data=8'hA5 -> one write, one rx_ack pulse, level=1, then rd_en -> rd_data=8'hA5 with rd_valid one cycle later.
- DEPTH=53: write 60 words 0..59 -> full after word 52, overflow=1, drop_count=7 (macro on) or 0 (off); 53 pops return 0..52 in order with pointer wrap.
- At level=53, simultaneous accept and rd_en -> level stays 53, no overflow, new word read last.
- loopback=1 with 3 words queued and a tx_busy model of 10 cycles -> exactly 3 tx_wr pulses, each at least 11 cycles apart, with tx_data in FIFO order; empty=1 at the end.
- rd_en with empty=1 -> rd_valid=0 and rd_data unchanged.
- reset=0 asserted during L_WAIT with level=4 -> all outputs at reset values immediately; no tx_wr after release.
